// File: rtl/player_pkg.sv
// Shared constants for the player movement controller: move codes, FSM states,
// map count and the key-priority encoder.
package player_pkg;

  localparam logic [2:0] MV_NONE  = 3'b000;
  localparam logic [2:0] MV_UP    = 3'b001;
  localparam logic [2:0] MV_LEFT  = 3'b010;
  localparam logic [2:0] MV_DOWN  = 3'b011;
  localparam logic [2:0] MV_RIGHT = 3'b100;

  localparam int unsigned NUM_MAPS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_COMMIT = 2'd2,
    ST_COOL   = 2'd3
  } state_t;

  // Fixed priority when several keys are active: up > down > left > right.
  function automatic logic [2:0] select_move(input logic up, input logic down,
                                             input logic left, input logic right);
    logic [2:0] code;
    code = MV_NONE;
    if (up)         code = MV_UP;
    else if (down)  code = MV_DOWN;
    else if (left)  code = MV_LEFT;
    else if (right) code = MV_RIGHT;
    return code;
  endfunction

endpackage

// File: rtl/player_move_ctrl_step_timer.sv
// Loadable down-counter with zero flag. Shared by the settle and cooldown phases;
// it stops at zero and holds there until the next load.
module step_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority; otherwise count down until zero is reached.
  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: picks a direction from the debounced keys, presents the
// move code to the collision detector, commits the detector's tile, handles map exits
// and enforces a cooldown between steps.
// Build option HOLD_REPEAT_EN: when defined a held key re-issues a move every step
// period; when undefined only a key's 0->1 transition issues a move.
module player_move_ctrl
  import player_pkg::*;
#(
  parameter int unsigned X_W      = 5,
  parameter int unsigned Y_W      = 4,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned STEP_DIV = 16,
  parameter int unsigned START_X  = 1,
  parameter int unsigned START_Y  = 1,
  parameter int unsigned EXIT_X   = 18,
  parameter int unsigned EXIT_Y   = 13
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           key_up,
  input  logic           key_down,
  input  logic           key_left,
  input  logic           key_right,
  output logic [2:0]     move,
  output logic [X_W-1:0] cur_x,
  output logic [Y_W-1:0] cur_y,
  output logic [1:0]     map_sel,
  input  logic [X_W-1:0] new_x,
  input  logic [Y_W-1:0] new_y,
  output logic           blocked,
  output logic           map_done
);

  localparam int unsigned CNT_MAX = (SETTLE > STEP_DIV) ? SETTLE : STEP_DIV;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [1:0]  LAST_MAP = 2'(NUM_MAPS - 1);

  state_t           r_state;
  logic [2:0]       r_move;
  logic [X_W-1:0]   r_cur_x;
  logic [Y_W-1:0]   r_cur_y;
  logic [1:0]       r_map_sel;
  logic             r_blocked;
  logic             r_map_done;

  logic [3:0]       w_keys_now;
  logic [3:0]       w_keys_act;
  logic [2:0]       w_sel;
  logic             w_same;
  logic             w_at_exit;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;

  assign w_keys_now = {key_up, key_down, key_left, key_right};

`ifdef HOLD_REPEAT_EN
  assign w_keys_act = w_keys_now;
`else
  logic [3:0] r_keys_prev;

  // Key history is tracked in every state, so a press that starts while busy never
  // produces a late edge once the controller returns to idle.
  always_ff @(posedge clk) begin
    if (reset)
      r_keys_prev <= '0;
    else
      r_keys_prev <= w_keys_now;
  end

  assign w_keys_act = w_keys_now & ~r_keys_prev;
`endif

  assign w_sel     = select_move(w_keys_act[3], w_keys_act[2], w_keys_act[1], w_keys_act[0]);
  assign w_same    = (new_x == r_cur_x) && (new_y == r_cur_y);
  assign w_at_exit = (new_x == X_W'(EXIT_X)) && (new_y == Y_W'(EXIT_Y));

  // Timer loads: settle count when a request starts, cooldown count on commit.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel != MV_NONE) begin
          w_load     = 1'b1;
          w_load_val = CNT_W'(SETTLE - 1);
        end
      end
      ST_COMMIT: begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(STEP_DIV - 1);
      end
      default: ;
    endcase
  end

  step_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Request/commit/cooldown sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_move     <= MV_NONE;
      r_cur_x    <= X_W'(START_X);
      r_cur_y    <= Y_W'(START_Y);
      r_map_sel  <= '0;
      r_blocked  <= 1'b0;
      r_map_done <= 1'b0;
    end else begin
      r_blocked  <= 1'b0;
      r_map_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel != MV_NONE) begin
            r_move  <= w_sel;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_zero)
            r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_move    <= MV_NONE;
          r_blocked <= w_same;
          if (w_at_exit) begin
            r_cur_x <= X_W'(START_X);
            r_cur_y <= Y_W'(START_Y);
            if (r_map_sel == LAST_MAP)
              r_map_done <= 1'b1;
            else
              r_map_sel <= r_map_sel + 2'd1;
          end else begin
            r_cur_x <= new_x;
            r_cur_y <= new_y;
          end
          r_state <= ST_COOL;
        end
        ST_COOL: begin
          if (w_zero)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign move     = r_move;
  assign cur_x    = r_cur_x;
  assign cur_y    = r_cur_y;
  assign map_sel  = r_map_sel;
  assign blocked  = r_blocked;
  assign map_done = r_map_done;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: a table of single-step transactions plus
// hand-written sequences for cooldown, mid-request key changes, reset and key hold.
module tb_player_move_ctrl;
  import player_pkg::*;

  localparam int unsigned SETTLE   = 2;
  localparam int unsigned STEP_DIV = 6;
  localparam int unsigned PERIOD   = SETTLE + STEP_DIV + 2;

  logic       clk;
  logic       reset;
  logic       key_up, key_down, key_left, key_right;
  logic [2:0] move;
  logic [4:0] cur_x;
  logic [3:0] cur_y;
  logic [1:0] map_sel;
  logic [4:0] new_x;
  logic [3:0] new_y;
  logic       blocked;
  logic       map_done;

  logic       det_auto;
  logic [4:0] tb_det_x;
  logic [3:0] tb_det_y;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [4:0] prev_x;
  logic [3:0] prev_y;

  typedef struct {
    logic [3:0] keys;      // {up, down, left, right}
    logic [4:0] det_x;
    logic [3:0] det_y;
    logic [2:0] exp_move;
    logic [4:0] exp_x;
    logic [3:0] exp_y;
    logic [1:0] exp_map;
    logic       exp_blocked;
    logic       exp_done;
  } vec_t;

  vec_t vecs[11];

  player_move_ctrl #(
    .X_W      (5),
    .Y_W      (4),
    .SETTLE   (SETTLE),
    .STEP_DIV (STEP_DIV),
    .START_X  (1),
    .START_Y  (1),
    .EXIT_X   (18),
    .EXIT_Y   (13)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .move      (move),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .map_sel   (map_sel),
    .new_x     (new_x),
    .new_y     (new_y),
    .blocked   (blocked),
    .map_done  (map_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collision detector stand-in: either a table value or a free-moving downward step.
  always_comb begin
    new_x = tb_det_x;
    new_y = tb_det_y;
    if (det_auto) begin
      new_x = cur_x;
      new_y = (move == MV_DOWN) ? 4'(cur_y + 4'd1) : cur_y;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
  endtask

  // One step transaction, entered and left at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    set_keys(v.keys);
    tb_det_x = v.det_x;
    tb_det_y = v.det_y;
    @(posedge clk); @(negedge clk);
    set_keys(4'b0000);
    chk($sformatf("v%0d move_issue", idx), move, v.exp_move);
    if (v.exp_move == MV_NONE) begin
      chk($sformatf("v%0d idle_x", idx), cur_x, v.exp_x);
      chk($sformatf("v%0d idle_y", idx), cur_y, v.exp_y);
      chk($sformatf("v%0d idle_map", idx), map_sel, v.exp_map);
      return;
    end
    repeat (SETTLE) @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d move_held", idx), move, v.exp_move);
    chk($sformatf("v%0d x_before_commit", idx), cur_x, prev_x);
    chk($sformatf("v%0d y_before_commit", idx), cur_y, prev_y);
    @(posedge clk); @(negedge clk);
    chk($sformatf("v%0d cur_x", idx), cur_x, v.exp_x);
    chk($sformatf("v%0d cur_y", idx), cur_y, v.exp_y);
    chk($sformatf("v%0d map_sel", idx), map_sel, v.exp_map);
    chk($sformatf("v%0d blocked", idx), blocked, v.exp_blocked);
    chk($sformatf("v%0d map_done", idx), map_done, v.exp_done);
    chk($sformatf("v%0d move_clear", idx), move, MV_NONE);
    @(posedge clk); @(negedge clk);
    chk($sformatf("v%0d blocked_pulse_end", idx), blocked, 1'b0);
    chk($sformatf("v%0d done_pulse_end", idx), map_done, 1'b0);
    repeat (STEP_DIV - 1) @(posedge clk);
    @(negedge clk);
    prev_x = v.exp_x;
    prev_y = v.exp_y;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_steps;

    vecs[0]  = '{4'b0001, 5'd2,  4'd1,  MV_RIGHT, 5'd2, 4'd1, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'b1000, 5'd2,  4'd1,  MV_UP,    5'd2, 4'd1, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{4'b1010, 5'd2,  4'd0,  MV_UP,    5'd2, 4'd0, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0111, 5'd2,  4'd1,  MV_DOWN,  5'd2, 4'd1, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0011, 5'd1,  4'd1,  MV_LEFT,  5'd1, 4'd1, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 5'd5,  4'd5,  MV_NONE,  5'd1, 4'd1, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 5'd18, 4'd13, MV_RIGHT, 5'd1, 4'd1, 2'd1, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 5'd18, 4'd13, MV_DOWN,  5'd1, 4'd1, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{4'b0001, 5'd18, 4'd13, MV_RIGHT, 5'd1, 4'd1, 2'd3, 1'b0, 1'b0};
    vecs[9]  = '{4'b1000, 5'd18, 4'd13, MV_UP,    5'd1, 4'd1, 2'd3, 1'b0, 1'b1};
    vecs[10] = '{4'b0010, 5'd1,  4'd1,  MV_LEFT,  5'd1, 4'd1, 2'd3, 1'b1, 1'b0};

    reset    = 1'b1;
    det_auto = 1'b0;
    tb_det_x = 5'd1;
    tb_det_y = 4'd1;
    set_keys(4'b0000);
    prev_x = 5'd1;
    prev_y = 4'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst move", move, MV_NONE);
    chk("rst cur_x", cur_x, 5'd1);
    chk("rst cur_y", cur_y, 4'd1);
    chk("rst map_sel", map_sel, 2'd0);
    chk("rst blocked", blocked, 1'b0);
    chk("rst map_done", map_done, 1'b0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Key pressed during cooldown must not start a request.
    set_keys(4'b0001);
    tb_det_x = 5'd2;
    tb_det_y = 4'd1;
    @(posedge clk); @(negedge clk);
    set_keys(4'b0000);
    repeat (SETTLE + 1) @(posedge clk);
    @(negedge clk);
    chk("cool commit_x", cur_x, 5'd2);
    key_left = 1'b1;
    tb_det_x = 5'd0;
    @(posedge clk); @(negedge clk);
    key_left = 1'b0;
    for (int c = 0; c < int'(STEP_DIV) + 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk("cool key_ignored_move", move, MV_NONE);
    end
    chk("cool cur_x_kept", cur_x, 5'd2);
    chk("cool cur_y_kept", cur_y, 4'd1);

    // Key change mid-request keeps the original move code.
    set_keys(4'b0001);
    tb_det_x = 5'd3;
    tb_det_y = 4'd1;
    @(posedge clk); @(negedge clk);
    set_keys(4'b1000);
    chk("req_change issue", move, MV_RIGHT);
    for (int c = 0; c < int'(SETTLE); c++) begin
      @(posedge clk); @(negedge clk);
      chk("req_change held", move, MV_RIGHT);
    end
    @(posedge clk); @(negedge clk);
    set_keys(4'b0000);
    chk("req_change cur_x", cur_x, 5'd3);
    chk("req_change move_clear", move, MV_NONE);
    repeat (STEP_DIV) @(posedge clk);
    @(negedge clk);

    // Reset during a request returns everything to the spawn state.
    set_keys(4'b0100);
    tb_det_x = 5'd3;
    tb_det_y = 4'd2;
    @(posedge clk); @(negedge clk);
    set_keys(4'b0000);
    chk("rst_req issue", move, MV_DOWN);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("rst_req move", move, MV_NONE);
    chk("rst_req cur_x", cur_x, 5'd1);
    chk("rst_req cur_y", cur_y, 4'd1);
    chk("rst_req map_sel", map_sel, 2'd0);
    chk("rst_req blocked", blocked, 1'b0);
    det_auto = 1'b1;
    key_down = 1'b1;
    @(posedge clk); @(negedge clk);
    key_down = 1'b0;
    chk("rst_req idle_issue", move, MV_DOWN);
    repeat (SETTLE + 1) @(posedge clk);
    @(negedge clk);
    chk("rst_req step_y", cur_y, 4'd2);
    repeat (STEP_DIV) @(posedge clk);
    @(negedge clk);

    // Held key for 100 cycles.
`ifdef HOLD_REPEAT_EN
    exp_steps = 100 / PERIOD;
`else
    exp_steps = 1;
`endif
    key_down = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    key_down = 1'b0;
    repeat (2 * PERIOD) @(posedge clk);
    @(negedge clk);
    chk("hold cur_y", cur_y, 32'd2 + exp_steps);
    chk("hold cur_x", cur_x, 5'd1);
    chk("hold move_idle", move, MV_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
